// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the single-port RAM: deserialises 10-bit MOSI
// frames into {cmd, data} words and shifts the RAM read byte out on MISO.
module spi_slave_ctrl #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int TXC_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [TXC_W-1:0] TXC_LOAD = TXC_W'(DATA_W - 1);
    localparam logic [TXC_W-1:0] TXC_ONE  = TXC_W'(1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-2:0] rx_sh_q, rx_sh_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               seen_q, seen_d;
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               tx_arm_q, tx_arm_d;
    logic               miso_q, miso_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        seen_d     = seen_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        tx_arm_d   = tx_arm_q;
        miso_d     = 1'b0;

        // Deselect wins over everything: drop the partial frame and any shift
        if (state_q != IDLE && SS_n) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_sh_d   = '0;
            tx_cnt_d  = '0;
            tx_arm_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = '0;
                    tx_cnt_d  = '0;
                    tx_arm_d  = 1'b0;
                    if (!SS_n) begin
                        state_d = CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    rx_sh_d   = {{(FRAME_W-2){1'b0}}, MOSI};
                    bit_cnt_d = CNT_ONE;
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (!seen_q) begin
                        state_d = READ_ADD;
                    end else begin
                        state_d = READ_DATA;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (bit_cnt_q != CNT_FULL) begin
                        rx_sh_d   = {rx_sh_q[FRAME_W-3:0], MOSI};
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                    if (bit_cnt_q == CNT_LAST) begin
                        rx_data_d  = {rx_sh_q, MOSI};
                        rx_valid_d = 1'b1;
                        if (state_q == READ_ADD) begin
                            seen_d = 1'b1;
                        end
                        if (state_q == READ_DATA) begin
                            seen_d = 1'b0;
                        end
                    end
                    // Read byte is accepted only once, strictly after the strobe
                    if (state_q == READ_DATA) begin
                        if (rx_valid_q) begin
                            tx_arm_d = 1'b1;
                        end
                        if (tx_arm_q && tx_valid) begin
                            miso_d   = tx_data[DATA_W-1];
                            tx_sh_d  = {tx_data[DATA_W-2:0], 1'b0};
                            tx_cnt_d = TXC_LOAD;
                            tx_arm_d = 1'b0;
                        end else if (tx_cnt_q != '0) begin
                            miso_d   = tx_sh_q[DATA_W-1];
                            tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
                            tx_cnt_d = tx_cnt_q - TXC_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            seen_q     <= 1'b0;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            tx_arm_q   <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            seen_q     <= seen_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_arm_q   <= tx_arm_d;
            miso_q     <= miso_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: frame-level reference timeline plus
// directed literal expectations and randomized frames.
module tb_spi_slave_ctrl;

    localparam int N = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    always #5 clk = ~clk;

    spi_slave_ctrl #(.FRAME_W(10), .DATA_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .SS_n(SS_n),
        .MOSI(MOSI),
        .MISO(MISO),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle timeline, filled frame by frame
    bit         exp_rv [N];
    bit         exp_set[N];
    logic [9:0] exp_val[N];
    bit         exp_miso[N];

    int         checks = 0;
    int         errors = 0;
    bit         cmp_en = 1'b0;
    logic [9:0] held = '0;
    bit         seen = 1'b0;

    logic [9:0] cap_rd = '0;
    int         rv_cnt = 0;
    int         ones = 0;
    logic [7:0] miso_word = '0;
    int         snap_cyc = -1;
    logic [7:0] snap = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && cyc < N) begin
            if (exp_set[cyc]) held = exp_val[cyc];
            chk("rx_valid", 32'(rx_valid), 32'(exp_rv[cyc]));
            chk("miso", 32'(MISO), 32'(exp_miso[cyc]));
            chk("rx_data", 32'(rx_data), 32'(held));
            if (rx_valid === 1'b1) begin
                cap_rd = rx_data;
                rv_cnt++;
            end
            if (MISO === 1'b1) ones++;
            miso_word = {miso_word[6:0], MISO};
            if (cyc == snap_cyc) snap = miso_word;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rst = 1'b0;
            SS_n = 1'b1;
            MOSI = 1'($urandom);
            tx_valid = 1'($urandom);
            tx_data = 8'($urandom);
        end
    endtask

    // One select window: m MOSI cycles after the select cycle, read byte
    // offered d cycles after the first legal cycle (d<0: never), optional
    // reset rst_at cycles into the window, then g deselected cycles.
    task automatic frame(input logic [9:0] f, input int m, input int d,
                         input logic [7:0] b, input int rst_at,
                         input int g);
        int t0, h, c, r, cy;
        bit full, is_rd;
        tick();
        t0 = cyc;
        rst = 1'b0;
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        tx_valid = 1'($urandom);
        tx_data = 8'($urandom);
        r = (rst_at >= 1) ? t0 + rst_at : -1;
        h = (r >= 0) ? r : t0 + m + 1;
        full = (r >= 0) ? (t0 + 11 <= r) : (m >= 10);
        is_rd = full && f[9] && seen;
        c = t0 + 12 + d;
        if (full) begin
            exp_rv[t0+11] = 1'b1;
            exp_set[t0+11] = 1'b1;
            exp_val[t0+11] = f;
            if (f[9]) seen = !seen;
        end
        if (is_rd && d >= 0 && c < h) begin
            for (int k = 0; k < 8; k++)
                if (c + 1 + k <= h) exp_miso[c+1+k] = b[7-k];
            snap_cyc = c + 8;
        end
        if (r >= 0) begin
            exp_set[r+1] = 1'b1;
            exp_val[r+1] = '0;
            seen = 1'b0;
        end
        for (int i = 1; i <= m; i++) begin
            tick();
            cy = cyc;
            tx_data = 8'($urandom);
            if (r >= 0 && cy >= r) begin
                rst = (cy == r);
                SS_n = 1'b1;
                MOSI = 1'($urandom);
                tx_valid = 1'($urandom);
            end else begin
                rst = 1'b0;
                SS_n = 1'b0;
                MOSI = (i <= 10) ? f[10-i] : 1'($urandom);
                if (!is_rd || cy < t0 + 11) begin
                    tx_valid = 1'($urandom);
                end else if (cy == t0 + 11 || d < 0 || cy < c) begin
                    tx_valid = 1'b0;
                end else if (cy == c) begin
                    tx_valid = 1'b1;
                    tx_data = b;
                end else begin
                    tx_valid = 1'($urandom);
                end
            end
        end
        idle(g);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=done", cyc);
        $fatal(1);
    end

    int rv0, ones0, m, d, ra;
    logic [9:0] fr;

    initial begin
        rst = 1'b1;
        SS_n = 1'b1;
        MOSI = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        chk("reset_rx_valid", 32'(rx_valid), 32'h0);
        chk("reset_miso", 32'(MISO), 32'h0);

        rv0 = rv_cnt;
        frame(10'h0A5, 10, -1, 8'h00, -1, 1);
        idle(3);
        chk("t1_rx_data", 32'(cap_rd), 32'h0A5);
        chk("t1_one_strobe", 32'(rv_cnt - rv0), 32'd1);

        frame(10'h13C, 12, -1, 8'h00, -1, 2);
        idle(2);
        chk("t2_rx_data", 32'(cap_rd), 32'h13C);

        ones0 = ones;
        frame(10'h207, 12, -1, 8'h00, -1, 2);
        idle(2);
        chk("t3_addr", 32'(cap_rd), 32'h207);
        chk("t3_addr_no_miso", 32'(ones - ones0), 32'd0);
        frame(10'h35A, 22, 0, 8'hC3, -1, 2);
        idle(2);
        chk("t3_data_frame", 32'(cap_rd), 32'h35A);
        chk("t3_miso_byte", 32'(snap), 32'hC3);

        ones0 = ones;
        frame(10'h3FF, 22, 0, 8'hFF, -1, 2);
        idle(2);
        chk("t4_no_miso", 32'(ones - ones0), 32'd0);
        chk("t4_rx_data", 32'(cap_rd), 32'h3FF);

        rv0 = rv_cnt;
        frame(10'h2AA, 6, -1, 8'h00, -1, 1);
        idle(2);
        chk("t5_abort_no_strobe", 32'(rv_cnt - rv0), 32'd0);
        frame(10'h0F0, 10, -1, 8'h00, -1, 1);
        idle(3);
        chk("t5_rx_data", 32'(cap_rd), 32'h0F0);

        frame(10'h3C3, 24, 0, 8'hA5, 15, 2);
        chk("t6_rx_data_cleared", 32'(rx_data), 32'h0);
        chk("t6_miso_low", 32'(MISO), 32'h0);
        ones0 = ones;
        frame(10'h3FF, 22, 0, 8'hFF, -1, 2);
        idle(2);
        chk("t6_seen_cleared", 32'(ones - ones0), 32'd0);
        frame(10'h300, 22, 1, 8'h5A, -1, 2);
        idle(2);
        chk("t6_read_after_rst", 32'(snap), 32'h5A);

        for (int n = 0; n < 250 && cyc < N - 64; n++) begin
            fr = 10'($urandom);
            m = ($urandom_range(0, 3) != 0) ? $urandom_range(10, 24)
                                           : $urandom_range(0, 9);
            d = ($urandom_range(0, 6) == 0) ? -1 : $urandom_range(0, 4);
            ra = -1;
            if (m >= 1 && $urandom_range(0, 19) == 0)
                ra = $urandom_range(1, m);
            frame(fr, m, d, 8'($urandom), ra, $urandom_range(1, 3));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
